tape_kcs_player: RTL and testbench

- Plays a loaded tape image back to the Sorcerer cassette input as a Kansas City Standard (KCS) FSK waveform.
- It is the reader/transmitter end of the tape path: the download logic writes TAP bytes into a buffer; this block pulls them through a valid/ready byte stream.
- Each byte is serialized as start bit, 8 data bits LSB-first, then stop bits.
- Its output drives the core's CASS_IN path in place of the external audio/UART pin.

---
 rtl/tape_kcs_pkg.sv | 44 ++++
 rtl/kcs_bit_gen.sv | 71 +++++++
 rtl/tape_kcs_player.sv | 173 +++++++++++++++++
 tb/tb_tape_kcs_player.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_kcs_pkg.sv
// Shared types and tone timing for the KCS tape player.
// Half-periods are derived from the system clock so a scaled clock keeps the same waveform shape.
package tape_kcs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEADER,
        FETCH,
        START,
        DATA,
        STOP
    } state_t;

    localparam int unsigned DEFAULT_CLK_HZ = 12_000_000;

    localparam logic [4:0] HALVES_ZERO_300  = 5'd8;
    localparam logic [4:0] HALVES_ONE_300   = 5'd16;
    localparam logic [4:0] HALVES_ZERO_1200 = 5'd2;
    localparam logic [4:0] HALVES_ONE_1200  = 5'd4;

    function automatic logic [15:0] half_lo_of(input int unsigned clk_hz);
        return 16'(clk_hz / 2400);
    endfunction

    function automatic logic [15:0] half_hi_of(input int unsigned clk_hz);
        return 16'(clk_hz / 4800);
    endfunction

    localparam logic [15:0] HALF_LO = half_lo_of(DEFAULT_CLK_HZ);
    localparam logic [15:0] HALF_HI = half_hi_of(DEFAULT_CLK_HZ);

    // Number of half-periods making up one bit; every case spans the same bit time.
    function automatic logic [4:0] halves_per_bit(input logic bit_val, input logic baud_1200);
        logic [4:0] n;
        case ({baud_1200, bit_val})
            2'b00:   n = HALVES_ZERO_300;
            2'b01:   n = HALVES_ONE_300;
            2'b10:   n = HALVES_ZERO_1200;
            default: n = HALVES_ONE_1200;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/kcs_bit_gen.sv
// KCS tone generator: plays one FSK bit per start strobe and pulses bit_done on its last clock.
// A new start may coincide with bit_done so consecutive bits run back to back with no gap.
module kcs_bit_gen
    import tape_kcs_pkg::*;
#(
    parameter logic [15:0] HALF_LO_CLKS = HALF_LO,
    parameter logic [15:0] HALF_HI_CLKS = HALF_HI
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_val,
    input  logic baud_1200,
    input  logic enable,
    input  logic clear,
    output logic tape_out,
    output logic bit_done
);

    logic        running;
    logic        cur_bit;
    logic        cur_baud;
    logic [15:0] half_cnt;
    logic [4:0]  half_idx;
    logic [15:0] half_last;
    logic [4:0]  halves_last;
    logic        half_end;

    assign half_last   = cur_bit ? (HALF_HI_CLKS - 16'd1) : (HALF_LO_CLKS - 16'd1);
    assign halves_last = halves_per_bit(cur_bit, cur_baud) - 5'd1;
    assign half_end    = running && enable && (half_cnt == half_last);
    assign bit_done    = half_end && (half_idx == halves_last);

    // Bit value and baud are captured only at start, so a baud change never cuts a bit short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running  <= 1'b0;
            cur_bit  <= 1'b0;
            cur_baud <= 1'b0;
            half_cnt <= 16'd0;
            half_idx <= 5'd0;
            tape_out <= 1'b0;
        end else if (clear) begin
            running  <= 1'b0;
            half_cnt <= 16'd0;
            half_idx <= 5'd0;
            tape_out <= 1'b0;
        end else begin
            if (half_end) begin
                tape_out <= ~tape_out;
            end
            if (start) begin
                running  <= 1'b1;
                cur_bit  <= bit_val;
                cur_baud <= baud_1200;
                half_cnt <= 16'd0;
                half_idx <= 5'd0;
            end else if (bit_done) begin
                running  <= 1'b0;
                half_cnt <= 16'd0;
                half_idx <= 5'd0;
            end else if (half_end) begin
                half_cnt <= 16'd0;
                half_idx <= half_idx + 5'd1;
            end else if (running && enable) begin
                half_cnt <= half_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/tape_kcs_player.sv
// Tape player top: sequences leader, byte frames and idle mark bits, pulling bytes over valid/ready.
// Tone generation lives in kcs_bit_gen; this level only decides which bit comes next.
module tape_kcs_player
    import tape_kcs_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 12_000_000,
    parameter logic [15:0] LEADER_BITS = 16'd2400,
    parameter int unsigned STOP_BITS   = 2
) (
    input  logic       CLK12,
    input  logic       RESET_N,
    input  logic       PLAY,
    input  logic       ABORT,
    input  logic       BAUD_1200,
    input  logic       MOTOR,
    input  logic [7:0] DATA_IN,
    input  logic       DATA_VALID,
    output logic       DATA_READY,
    input  logic       DATA_EOF,
    output logic       TAPE_OUT,
    output logic       BUSY
);

    localparam int unsigned STOP_N    = (STOP_BITS < 1) ? 1 : ((STOP_BITS > 2) ? 2 : STOP_BITS);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_N - 1);

    state_t      state, state_next;
    logic [15:0] leader_cnt, leader_next;
    logic [3:0]  bit_idx, idx_next;
    logic [7:0]  shreg, shreg_next;
    logic        filler, filler_next;
    logic        play_d;
    logic        play_rise;
    logic        bit_start;
    logic        bit_val;
    logic        bit_done;
    logic        ready;

    assign play_rise  = PLAY && !play_d;
    assign DATA_READY = ready;
    assign BUSY       = (state != IDLE);

    kcs_bit_gen #(
        .HALF_LO_CLKS(half_lo_of(CLK_HZ)),
        .HALF_HI_CLKS(half_hi_of(CLK_HZ))
    ) u_bit_gen (
        .clk      (CLK12),
        .rst_n    (RESET_N),
        .start    (bit_start),
        .bit_val  (bit_val),
        .baud_1200(BAUD_1200),
        .enable   (MOTOR),
        .clear    (ABORT),
        .tape_out (TAPE_OUT),
        .bit_done (bit_done)
    );

    // play_d resets high so a PLAY level already present at reset release is not taken as an edge.
    always_ff @(posedge CLK12 or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            leader_cnt <= 16'd0;
            bit_idx    <= 4'd0;
            shreg      <= 8'd0;
            filler     <= 1'b0;
            play_d     <= 1'b1;
        end else begin
            state      <= state_next;
            leader_cnt <= leader_next;
            bit_idx    <= idx_next;
            shreg      <= shreg_next;
            filler     <= filler_next;
            play_d     <= PLAY;
        end
    end

    // bit_done is already gated by MOTOR, so a stopped motor freezes every bit-driven transition.
    always_comb begin
        state_next  = state;
        leader_next = leader_cnt;
        idx_next    = bit_idx;
        shreg_next  = shreg;
        filler_next = filler;
        bit_start   = 1'b0;
        bit_val     = 1'b1;
        ready       = 1'b0;
        if (ABORT) begin
            state_next  = IDLE;
            leader_next = 16'd0;
            idx_next    = 4'd0;
            filler_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (play_rise && MOTOR) begin
                        leader_next = 16'd0;
                        if (LEADER_BITS == 16'd0) begin
                            state_next = FETCH;
                        end else begin
                            bit_start  = 1'b1;
                            state_next = LEADER;
                        end
                    end
                end
                LEADER: begin
                    if (bit_done) begin
                        if (leader_cnt == LEADER_BITS - 16'd1) begin
                            leader_next = 16'd0;
                            state_next  = FETCH;
                        end else begin
                            leader_next = leader_cnt + 16'd1;
                            bit_start   = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    // filler marks an idle mark bit in flight while no byte is available.
                    if (filler) begin
                        if (bit_done) begin
                            filler_next = 1'b0;
                        end
                    end else if (MOTOR) begin
                        ready = 1'b1;
                        if (DATA_VALID) begin
                            shreg_next = DATA_IN;
                            bit_start  = 1'b1;
                            bit_val    = 1'b0;
                            state_next = START;
                        end else if (DATA_EOF) begin
                            state_next = IDLE;
                        end else begin
                            filler_next = 1'b1;
                            bit_start   = 1'b1;
                        end
                    end
                end
                START: begin
                    if (bit_done) begin
                        idx_next   = 4'd0;
                        bit_start  = 1'b1;
                        bit_val    = shreg[0];
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_start = 1'b1;
                        if (bit_idx == 4'd7) begin
                            idx_next   = 4'd0;
                            state_next = STOP;
                        end else begin
                            idx_next = bit_idx + 4'd1;
                            bit_val  = shreg[bit_idx[2:0] + 3'd1];
                        end
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (bit_idx == LAST_STOP) begin
                            idx_next   = 4'd0;
                            state_next = FETCH;
                        end else begin
                            idx_next  = bit_idx + 4'd1;
                            bit_start = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tape_kcs_player.sv
// Bench for tape_kcs_player on a 48 kHz clock: half-periods are 20/10 clocks, bits 40 (1200) or 160 (300).
// TAPE_OUT toggles are timestamped and decoded back into frame bits independently of the design.
module tb_tape_kcs_player;

    localparam int HL      = 20;
    localparam int HH      = 10;
    localparam int LATENCY = HL + 1;

    logic       CLK12 = 1'b0;
    logic       RESET_N;
    logic       PLAY;
    logic       ABORT;
    logic       BAUD_1200;
    logic       MOTOR;
    logic [7:0] DATA_IN;
    logic       DATA_VALID;
    logic       DATA_READY;
    logic       DATA_EOF;
    logic       TAPE_OUT;
    logic       BUSY;

    typedef struct {
        logic       baud;
        logic [7:0] data;
        int         lead_len;
        int         lead_tog;
        int         frame_len;
        int         frame_tog;
    } vec_t;

    vec_t vecs[5];
    int   cyc = 0;
    int   tog_q[$];
    logic prev_tape = 1'b0;
    int   n_vectors = 0;
    int   n_miscompares = 0;

    tape_kcs_player #(
        .CLK_HZ(48_000),
        .LEADER_BITS(16'd4),
        .STOP_BITS(2)
    ) dut (
        .CLK12(CLK12),
        .RESET_N(RESET_N),
        .PLAY(PLAY),
        .ABORT(ABORT),
        .BAUD_1200(BAUD_1200),
        .MOTOR(MOTOR),
        .DATA_IN(DATA_IN),
        .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY),
        .DATA_EOF(DATA_EOF),
        .TAPE_OUT(TAPE_OUT),
        .BUSY(BUSY)
    );

    always #5 CLK12 = ~CLK12;

    always @(posedge CLK12) cyc <= cyc + 1;

    always @(negedge CLK12) begin
        if (TAPE_OUT !== prev_tape) tog_q.push_back(cyc);
        prev_tape = TAPE_OUT;
    end

    function automatic int count_tog(input int lo, input int hi);
        int n = 0;
        foreach (tog_q[i]) if (tog_q[i] > lo && tog_q[i] <= hi) n++;
        return n;
    endfunction

    function automatic int first_tog_after(input int lo);
        foreach (tog_q[i]) if (tog_q[i] > lo) return tog_q[i];
        return -1;
    endfunction

    // Rebuilds the 11 frame bits (start first) from half-period lengths; -1 if the waveform is malformed.
    function automatic int decode_frame(input int lo, input int hi, input logic baud);
        int          iv[$];
        int          prev = lo + 1;
        int          pos = 0;
        int          nb = 0;
        int          step;
        logic        bitv;
        logic [10:0] bits = '0;
        foreach (tog_q[i]) begin
            if (tog_q[i] > lo && tog_q[i] <= hi) begin
                iv.push_back(tog_q[i] - prev);
                prev = tog_q[i];
            end
        end
        while (pos < iv.size() && nb < 11) begin
            if (iv[pos] == HL) begin
                bitv = 1'b0;
                step = baud ? 2 : 8;
            end else if (iv[pos] == HH) begin
                bitv = 1'b1;
                step = baud ? 4 : 16;
            end else begin
                return -1;
            end
            bits[4'(nb)] = bitv;
            pos += step;
            nb++;
        end
        return (nb == 11) ? int'(bits) : -1;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        n_vectors++;
        if (actual != expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_for(input bit want_ready, input string name, output int t);
        t = -1;
        for (int n = 0; n < 4000; n++) begin
            @(negedge CLK12);
            if (want_ready ? (DATA_READY == 1'b1) : (BUSY == 1'b0)) begin
                t = cyc;
                return;
            end
        end
        n_vectors++;
        n_miscompares++;
        $display("[TB] FAIL %s: no event within 4000 cycles", name);
    endtask

    task automatic apply_stimulus(input logic baud, input logic [7:0] data, input logic valid);
        BAUD_1200  = baud;
        DATA_IN    = data;
        DATA_VALID = valid;
        DATA_EOF   = 1'b0;
    endtask

    task automatic start_play(input logic baud, input logic [7:0] data, input logic valid,
                              output int p, output int r);
        apply_stimulus(baud, data, valid);
        @(negedge CLK12);
        PLAY = 1'b0;
        @(negedge CLK12);
        PLAY = 1'b1;
        p = cyc;
        wait_for(1'b1, "ready_rise", r);
        if (valid) begin
            @(negedge CLK12);
            DATA_VALID = 1'b0;
            DATA_EOF   = 1'b1;
        end
    endtask

    task automatic run_vector(input vec_t v, input int id);
        int p, r, b;
        start_play(v.baud, v.data, 1'b1, p, r);
        wait_for(1'b0, "busy_fall", b);
        check_output($sformatf("vec%0d_lead_len", id), r - p, v.lead_len);
        check_output($sformatf("vec%0d_lead_tog", id), count_tog(p, r), v.lead_tog);
        check_output($sformatf("vec%0d_frame_len", id), b - r, v.frame_len);
        check_output($sformatf("vec%0d_frame_tog", id), count_tog(r, b), v.frame_tog);
        check_output($sformatf("vec%0d_start_latency", id), first_tog_after(r) - r, LATENCY);
        check_output($sformatf("vec%0d_frame_bits", id), decode_frame(r, b, v.baud),
                     int'({2'b11, v.data, 1'b0}));
    endtask

    initial begin
        int   p, r, h, b, pulses, bad;
        logic lvl;

        vecs[0] = '{1'b1, 8'h55, 161, 16, 442, 34};
        vecs[1] = '{1'b0, 8'h00, 641, 64, 1762, 104};
        vecs[2] = '{1'b1, 8'hFF, 161, 16, 442, 42};
        vecs[3] = '{1'b0, 8'h0F, 641, 64, 1762, 136};
        vecs[4] = '{1'b1, 8'hA3, 161, 16, 442, 34};

        RESET_N    = 1'b0;
        PLAY       = 1'b0;
        ABORT      = 1'b0;
        BAUD_1200  = 1'b1;
        MOTOR      = 1'b1;
        DATA_IN    = 8'h00;
        DATA_VALID = 1'b0;
        DATA_EOF   = 1'b0;
        repeat (3) @(negedge CLK12);
        check_output("reset_tape_out", int'(TAPE_OUT), 0);
        check_output("reset_ready", int'(DATA_READY), 0);
        check_output("reset_busy", int'(BUSY), 0);
        RESET_N = 1'b1;

        MOTOR = 1'b0;
        @(negedge CLK12);
        PLAY = 1'b1;
        repeat (10) @(negedge CLK12);
        check_output("motor_off_play_busy", int'(BUSY), 0);
        PLAY  = 1'b0;
        MOTOR = 1'b1;

        for (int i = 0; i < 5; i++) run_vector(vecs[i], i);

        // Byte arrives 100 clocks into FETCH: three idle mark bits, then the frame.
        start_play(1'b1, 8'h3C, 1'b0, p, r);
        pulses = 1;
        while (cyc < r + 100) begin
            @(negedge CLK12);
            if (cyc == r + 50) PLAY = 1'b0;
            if (cyc == r + 55) PLAY = 1'b1;
            if (DATA_READY) pulses++;
        end
        DATA_VALID = 1'b1;
        wait_for(1'b1, "filler_accept", h);
        @(negedge CLK12);
        DATA_VALID = 1'b0;
        DATA_EOF   = 1'b1;
        wait_for(1'b0, "filler_busy_fall", b);
        check_output("filler_accept_time", h - r, 123);
        check_output("filler_ready_pulses", pulses, 3);
        check_output("filler_mark_tog", count_tog(r, h), 12);
        check_output("filler_frame_len", b - h, 442);
        check_output("filler_frame_bits", decode_frame(h, b, 1'b1), int'({2'b11, 8'h3C, 1'b0}));

        // Motor stops 9 clocks into data bit 3 for 28 clocks.
        start_play(1'b1, 8'hC5, 1'b1, p, r);
        while (cyc < r + 170) @(negedge CLK12);
        MOTOR = 1'b0;
        lvl   = TAPE_OUT;
        bad   = 0;
        repeat (28) begin
            @(negedge CLK12);
            if (TAPE_OUT !== lvl || DATA_READY !== 1'b0) bad++;
        end
        MOTOR = 1'b1;
        wait_for(1'b0, "motor_busy_fall", b);
        check_output("motor_frozen_violations", bad, 0);
        check_output("motor_resume_toggle", first_tog_after(r + 170) - r, 209);
        check_output("motor_frame_len", b - r, 470);
        check_output("motor_frame_tog", count_tog(r, b), 34);

        // Abort in the middle of data bit 5, then replay with the full leader.
        start_play(1'b1, 8'hFF, 1'b1, p, r);
        while (cyc < r + 255) @(negedge CLK12);
        check_output("abort_pre_level", int'(TAPE_OUT), 1);
        ABORT = 1'b1;
        @(negedge CLK12);
        ABORT = 1'b0;
        check_output("abort_busy", int'(BUSY), 0);
        check_output("abort_tape_out", int'(TAPE_OUT), 0);
        check_output("abort_ready", int'(DATA_READY), 0);
        repeat (40) @(negedge CLK12);
        check_output("abort_stays_idle", int'(BUSY), 0);
        run_vector(vecs[0], 10);

        // Reset during the first stop bit while PLAY stays high.
        start_play(1'b1, 8'h81, 1'b1, p, r);
        while (cyc < r + 375) @(negedge CLK12);
        check_output("reset_pre_level", int'(TAPE_OUT), 1);
        RESET_N = 1'b0;
        #1;
        check_output("midreset_tape_out", int'(TAPE_OUT), 0);
        check_output("midreset_busy", int'(BUSY), 0);
        check_output("midreset_ready", int'(DATA_READY), 0);
        @(negedge CLK12);
        RESET_N    = 1'b1;
        DATA_VALID = 1'b1;
        DATA_EOF   = 1'b0;
        pulses     = 0;
        repeat (100) begin
            @(negedge CLK12);
            if (DATA_READY || BUSY) pulses++;
        end
        check_output("postreset_no_ready", pulses, 0);
        run_vector(vecs[4], 11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
